// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, reads the combinational instruction ROM and buffers
// {pc, instr} pairs in a small FIFO that decode drains over valid/ready.
// Ports:
//   clk, reset (async, active-low)
//   imem_addr/imem_rd        : byte address to / word from the instruction ROM
//   redirect_valid/_pc       : load a new PC and flush the queue
//   out_valid/out_ready      : decode handshake; out_instr/out_pc/out_pcplus4 payload
//   fetch_err                : sticky misaligned-redirect / out-of-range flag
//   occupancy                : number of valid queue entries
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned QDEPTH     = 2,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [31:0]               imem_addr,
    input  logic [31:0]               imem_rd,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [31:0]               out_pc,
    output logic [31:0]               out_pcplus4,
    output logic                      fetch_err,
    output logic [$clog2(QDEPTH):0]   occupancy
);

    localparam int unsigned PTR_W    = $clog2(QDEPTH);
    localparam int unsigned OCC_W    = PTR_W + 1;
    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t             q [QDEPTH];
    logic [31:0]        pc;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;

    logic               pop_c;
    logic               enq_c;
    logic               in_range_c;
    logic               full_c;
    logic [OCC_W-1:0]   occ_next_c;

    // Handshake, enqueue qualification and next occupancy
    always_comb begin
        pop_c      = 1'b0;
        enq_c      = 1'b0;
        in_range_c = 1'b0;
        full_c     = 1'b0;
        occ_next_c = occupancy;

        in_range_c = (pc < PC_LIMIT);
        full_c     = (occupancy == OCC_W'(QDEPTH));
        pop_c      = (occupancy != '0) && out_ready;
        enq_c      = !fetch_err && !redirect_valid && in_range_c && (!full_c || pop_c);

        case ({enq_c, pop_c})
            2'b10:   occ_next_c = occupancy + OCC_W'(1);
            2'b01:   occ_next_c = occupancy - OCC_W'(1);
            default: occ_next_c = occupancy;
        endcase
    end

    // PC, queue storage, pointers and error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            fetch_err <= 1'b0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                q[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Redirect beats enqueue; any same-cycle pop is simply part of the flush
            pc        <= redirect_pc;
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            if (redirect_pc[1:0] != 2'b00) begin
                fetch_err <= 1'b1;
            end
        end else begin
            if (enq_c) begin
                q[tail] <= '{pc: pc, instr: imem_rd};
                tail    <= tail + PTR_W'(1);
                pc      <= pc + 32'd4;
            end
            if (pop_c) begin
                head <= head + PTR_W'(1);
            end
            occupancy <= occ_next_c;
            if (!fetch_err && !in_range_c) begin
                fetch_err <= 1'b1;
            end
        end
    end

    // Outputs come only from registered state; payload is forced to zero when empty
    always_comb begin
        imem_addr   = pc;
        out_valid   = (occupancy != '0);
        out_instr   = 32'd0;
        out_pc      = 32'd0;
        out_pcplus4 = 32'd0;
        if (out_valid) begin
            out_instr   = q[head].instr;
            out_pc      = q[head].pc;
            out_pcplus4 = q[head].pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic        fetch_err;
    logic [1:0]  occupancy;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_queue #(
        .RESET_PC   (32'h0000_0000),
        .QDEPTH     (2),
        .IMEM_WORDS (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pcplus4    (out_pcplus4),
        .fetch_err      (fetch_err),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // ROM word i = 0x1000_0000 + i; garbage outside the array
    assign imem_rd = (imem_addr < 32'd256) ? (32'h1000_0000 + 32'(imem_addr[7:2])) : 32'hDEAD_BEEF;

    function automatic logic [31:0] rw(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [1:0]  eocc;
        logic        eerr;
        logic [31:0] eaddr;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic ev,
                                input logic [31:0] epc, input logic [31:0] einstr,
                                input logic [1:0] eocc, input logic eerr,
                                input logic [31:0] eaddr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev;
        v.epc = epc; v.einstr = einstr; v.eocc = eocc; v.eerr = eerr; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] epc,
                             input logic [31:0] einstr, input logic [1:0] eocc,
                             input logic eerr, input logic [31:0] eaddr);
        chk({tag, ".out_valid"},   32'(out_valid),   32'(ev));
        chk({tag, ".out_pc"},      out_pc,           ev ? epc : 32'd0);
        chk({tag, ".out_instr"},   out_instr,        ev ? einstr : 32'd0);
        chk({tag, ".out_pcplus4"}, out_pcplus4,      ev ? epc + 32'd4 : 32'd0);
        chk({tag, ".occupancy"},   32'(occupancy),   32'(eocc));
        chk({tag, ".fetch_err"},   32'(fetch_err),   32'(eerr));
        chk({tag, ".imem_addr"},   imem_addr,        eaddr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    vec_t vt [25];

    // Reference model state
    logic [31:0] mq_pc [$];
    logic [31:0] mq_in [$];
    logic [31:0] m_pc;
    logic        m_err;

    initial begin
        logic m_pop;
        logic m_enq;
        logic m_oor;
        logic ev;

        reset          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Straight-line, stall, redirect, misaligned and end-of-ROM vectors
        vt[0]  = mk(0,1,0,32'h0,   1,32'h0,  rw(0), 2'd1,0,32'h4);
        vt[1]  = mk(0,1,0,32'h0,   1,32'h4,  rw(1), 2'd1,0,32'h8);
        vt[2]  = mk(0,1,0,32'h0,   1,32'h8,  rw(2), 2'd1,0,32'hC);
        vt[3]  = mk(1,1,0,32'h0,   0,32'h0,  32'h0, 2'd0,0,32'h0);
        vt[4]  = mk(0,0,0,32'h0,   1,32'h0,  rw(0), 2'd1,0,32'h4);
        vt[5]  = mk(0,0,0,32'h0,   1,32'h0,  rw(0), 2'd2,0,32'h8);
        vt[6]  = mk(0,0,0,32'h0,   1,32'h0,  rw(0), 2'd2,0,32'h8);
        vt[7]  = mk(0,0,0,32'h0,   1,32'h0,  rw(0), 2'd2,0,32'h8);
        vt[8]  = mk(0,0,0,32'h0,   1,32'h0,  rw(0), 2'd2,0,32'h8);
        vt[9]  = mk(0,1,0,32'h0,   1,32'h4,  rw(1), 2'd2,0,32'hC);
        vt[10] = mk(0,1,0,32'h0,   1,32'h8,  rw(2), 2'd2,0,32'h10);
        vt[11] = mk(0,1,0,32'h0,   1,32'hC,  rw(3), 2'd2,0,32'h14);
        vt[12] = mk(0,1,1,32'h40,  0,32'h0,  32'h0, 2'd0,0,32'h40);
        vt[13] = mk(0,1,0,32'h0,   1,32'h40, rw(16),2'd1,0,32'h44);
        vt[14] = mk(0,1,0,32'h0,   1,32'h44, rw(17),2'd1,0,32'h48);
        vt[15] = mk(0,1,1,32'h42,  0,32'h0,  32'h0, 2'd0,1,32'h42);
        vt[16] = mk(0,1,0,32'h0,   0,32'h0,  32'h0, 2'd0,1,32'h42);
        vt[17] = mk(0,1,1,32'h10,  0,32'h0,  32'h0, 2'd0,1,32'h10);
        vt[18] = mk(0,1,0,32'h0,   0,32'h0,  32'h0, 2'd0,1,32'h10);
        vt[19] = mk(1,1,0,32'h0,   0,32'h0,  32'h0, 2'd0,0,32'h0);
        vt[20] = mk(0,1,1,32'hF8,  0,32'h0,  32'h0, 2'd0,0,32'hF8);
        vt[21] = mk(0,1,0,32'h0,   1,32'hF8, rw(62),2'd1,0,32'hFC);
        vt[22] = mk(0,1,0,32'h0,   1,32'hFC, rw(63),2'd1,0,32'h100);
        vt[23] = mk(0,1,0,32'h0,   0,32'h0,  32'h0, 2'd0,1,32'h100);
        vt[24] = mk(0,1,0,32'h0,   0,32'h0,  32'h0, 2'd0,1,32'h100);

        step();
        step();
        check_all("reset_hold", 0, 0, 0, 2'd0, 0, 32'h0);
        reset = 1'b1;
        #1;
        check_all("reset_state", 0, 0, 0, 2'd0, 0, 32'h0);

        for (int i = 0; i < 25; i++) begin
            out_ready      = vt[i].rdy;
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            if (vt[i].rst) begin
                do_reset();
            end else begin
                step();
            end
            check_all($sformatf("vec%0d", i), vt[i].ev, vt[i].epc, vt[i].einstr,
                      vt[i].eocc, vt[i].eerr, vt[i].eaddr);
        end
        redirect_valid = 1'b0;

        // Out-of-range with a stalled full queue: queued entries still drain
        out_ready = 1'b0;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hF8;
        step();
        redirect_valid = 1'b0;
        check_all("drain0", 0, 0, 0, 2'd0, 0, 32'hF8);
        step();
        check_all("drain1", 1, 32'hF8, rw(62), 2'd1, 0, 32'hFC);
        step();
        check_all("drain2", 1, 32'hF8, rw(62), 2'd2, 0, 32'h100);
        step();
        check_all("drain3", 1, 32'hF8, rw(62), 2'd2, 1, 32'h100);
        out_ready = 1'b1;
        step();
        check_all("drain4", 1, 32'hFC, rw(63), 2'd1, 1, 32'h100);
        step();
        check_all("drain5", 0, 0, 0, 2'd0, 1, 32'h100);

        // Asynchronous reset between edges with a full queue
        out_ready = 1'b0;
        do_reset();
        step();
        step();
        check_all("pre_async", 1, 32'h0, rw(0), 2'd2, 0, 32'h8);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 2'd0, 0, 32'h0);
        step();
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        check_all("restart0", 1, 32'h0, rw(0), 2'd1, 0, 32'h4);
        step();
        check_all("restart1", 1, 32'h4, rw(1), 2'd1, 0, 32'h8);

        // Randomized run against a queue-level model
        do_reset();
        mq_pc.delete();
        mq_in.delete();
        m_pc  = 32'h0;
        m_err = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                redirect_valid = 1'b0;
                do_reset();
                mq_pc.delete();
                mq_in.delete();
                m_pc  = 32'h0;
                m_err = 1'b0;
            end else begin
                out_ready      = ($urandom_range(0, 9) < 7);
                redirect_valid = ($urandom_range(0, 11) == 0);
                case ($urandom_range(0, 4))
                    0:       redirect_pc = 32'($urandom_range(0, 63)) * 32'd4;
                    1:       redirect_pc = 32'hF0 + 32'($urandom_range(0, 3)) * 32'd4;
                    2:       redirect_pc = 32'($urandom_range(0, 255));
                    3:       redirect_pc = $urandom;
                    default: redirect_pc = 32'($urandom_range(0, 15)) * 32'd4;
                endcase

                m_pop = (mq_pc.size() != 0) && out_ready;
                if (redirect_valid) begin
                    mq_pc.delete();
                    mq_in.delete();
                    m_pc = redirect_pc;
                    if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
                end else begin
                    m_enq = !m_err && (m_pc < 32'd256) && ((mq_pc.size() < 2) || m_pop);
                    m_oor = !m_err && (m_pc >= 32'd256);
                    if (m_pop) begin
                        void'(mq_pc.pop_front());
                        void'(mq_in.pop_front());
                    end
                    if (m_enq) begin
                        mq_pc.push_back(m_pc);
                        mq_in.push_back(32'h1000_0000 + m_pc / 32'd4);
                        m_pc = m_pc + 32'd4;
                    end
                    if (m_oor) m_err = 1'b1;
                end
                step();
            end
            ev = (mq_pc.size() != 0);
            check_all($sformatf("rnd%0d", c), ev,
                      ev ? mq_pc[0] : 32'd0, ev ? mq_in[0] : 32'd0,
                      2'(mq_pc.size()), m_err, m_pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
